// File: rtl/softmax_div_sched_pkg.sv
// Shared types and constants for the softmax divider scheduler.
package softmax_div_pkg;
  localparam int DATA_W_DEF     = 32;
  localparam int NUM_STAGES_DEF = 64;
  localparam int LEN_W_DEF      = 16;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  // Tag travelling alongside each in-flight divide.
  typedef struct packed {
    logic vld;
    logic last;
  } tag_t;

  // Divider latency in enabled cycles for a given stage count.
  function automatic int lat_of(input int num_stages);
    return num_stages - 1;
  endfunction

  localparam int LAT = lat_of(NUM_STAGES_DEF);
endpackage

// File: rtl/softmax_div_sched_if.sv
// Command, dividend and quotient streams of the softmax divider scheduler.
interface softmax_div_sched_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
);
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] divisor;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport slave (
    input  start, len, divisor, s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  modport master (
    output start, len, divisor, s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/softmax_div_sched_tag_pipe.sv
// (vld, last) tag shift register that mirrors the divider pipeline.
module div_tag_pipe
  import softmax_div_pkg::*;
#(
  parameter int DEPTH = LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  tag_t tag_in,
  output tag_t tag_out
);
  tag_t [DEPTH-1:0] vld_pipe_q, vld_pipe_d;

  // Shift one slot per enabled cycle; hold otherwise.
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    if (en) vld_pipe_d = {vld_pipe_q[DEPTH-2:0], tag_in};
  end

  // Tag state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe_q <= '0;
    else        vld_pipe_q <= vld_pipe_d;
  end

  assign tag_out = vld_pipe_q[DEPTH-1];
endmodule

// File: rtl/softmax_div_sched.sv
// Sequences a shared stall-capable pipelined divider for softmax normalisation:
// one divisor per vector, a stream of dividends in, quotients out.
module softmax_div_sched
  import softmax_div_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int LEN_W      = LEN_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  softmax_div_sched_if.slave  bus,
  output logic                busy,
  output logic                done,
  output logic                err_div0,
  output logic                div_en,
  output logic [DATA_W-1:0]   div_a,
  output logic [DATA_W-1:0]   div_b,
  input  logic [DATA_W-1:0]   div_q
);
  localparam int DEPTH = lat_of(NUM_STAGES);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic [DATA_W-1:0] div_b_q, div_b_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  tag_t tag_in, tag_out;
  logic adv, accept;

  // The pipe only stalls when a finished result is stuck behind a held output.
  assign adv         = !(tag_out.vld && m_valid_q && !bus.m_ready);
  assign bus.s_ready = (state_q == RUN) && adv && (issued_q < len_q);
  assign accept      = bus.s_valid && bus.s_ready;

  assign tag_in.vld  = accept;
  assign tag_in.last = accept && (issued_q == len_q - LEN_W'(1));

  div_tag_pipe #(.DEPTH(DEPTH)) u_tags (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (adv),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Next-state: command decode, issue counting, output register, retire.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    issued_d  = issued_q;
    div_b_d   = div_b_q;
    err_d     = err_q;
    done_d    = 1'b0;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else if (bus.len == '0) begin
            done_d = 1'b1;
          end else begin
            div_b_d  = bus.divisor;
            len_d    = bus.len;
            issued_d = '0;
            err_d    = 1'b0;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        if (accept) begin
          issued_d = issued_q + LEN_W'(1);
          if (issued_d == len_q) state_d = DRAIN;
        end
      end
      DRAIN:   ;
      default: state_d = IDLE;
    endcase

    if (tag_out.vld && adv) begin
      m_data_d  = div_q;
      m_last_d  = tag_out.last;
      m_valid_d = 1'b1;
    end else if (bus.m_ready) begin
      m_valid_d = 1'b0;
    end

    // Final quotient handed off: vector is complete.
    if (state_q != IDLE && m_valid_q && bus.m_ready && m_last_q) begin
      done_d  = 1'b1;
      state_d = IDLE;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      issued_q  <= '0;
      div_b_q   <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      div_b_q   <= div_b_d;
      err_q     <= err_d;
      done_q    <= done_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_last  = m_last_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign err_div0    = err_q;
  // Enable is forced low while reset is held so the divider sees a quiet pipe.
  assign div_en      = adv && rst_n;
  assign div_a       = bus.s_data;
  assign div_b       = div_b_q;
endmodule

// File: tb/tb_softmax_div_sched.sv
// Scoreboard bench for softmax_div_sched with a behavioural stalling divider.
module tb_softmax_div_sched;
  localparam int DW  = 32;
  localparam int LW  = 16;
  localparam int NS  = 64;
  localparam int LAT = NS - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  softmax_div_sched_if #(.DATA_W(DW), .LEN_W(LW)) bus();
  logic          busy, done, err_div0, div_en;
  logic [DW-1:0] div_a, div_b, div_q;

  softmax_div_sched #(.DATA_W(DW), .NUM_STAGES(NS), .LEN_W(LW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err_div0 (err_div0),
    .div_en   (div_en),
    .div_a    (div_a),
    .div_b    (div_b),
    .div_q    (div_q)
  );

  // Divider environment: LAT enabled cycles from issue to div_q.
  logic [DW-1:0] dpipe [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) dpipe[i] <= '0;
    end else if (div_en) begin
      dpipe[0] <= (div_b != '0) ? div_a / div_b : '1;
      for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
    end
  end
  assign div_q = dpipe[LAT-1];

  typedef struct {
    logic [DW-1:0] q;
    logic          last;
  } exp_t;
  exp_t          sb[$];
  logic [DW-1:0] dvals[$];
  logic [DW-1:0] cur_div;

  int total = 0, bad = 0;
  int cyc = 0, out_cnt = 0, done_cnt = 0;
  int rmode = 0;
  int lat_arm = 0, first_acc_cyc = 0, first_val_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready pattern: 0 always ready, 1 toggle, 2 random.
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = !bus.m_ready;
        default: bus.m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pop expected quotient on every output handshake.
  logic          hold_v = 1'b0;
  logic [DW-1:0] hold_d;
  logic          hold_l;
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      if (done) done_cnt++;
      if (hold_v) begin
        chk("m_valid_held", bus.m_valid, 1);
        chk("m_data_stable", bus.m_data, hold_d);
        chk("m_last_stable", bus.m_last, hold_l);
      end
      if (!div_en) chk("div_en_low_only_when_held", bus.m_valid && !bus.m_ready, 1);
      if (bus.m_valid && lat_arm != 0) begin
        first_val_cyc = cyc;
        lat_arm = 0;
      end
      if (bus.m_valid && bus.m_ready) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_output: got %0h want none", bus.m_data);
        end else begin
          e = sb.pop_front();
          chk("quotient", bus.m_data, e.q);
          chk("m_last", bus.m_last, e.last);
          out_cnt++;
        end
      end
      hold_v = bus.m_valid && !bus.m_ready;
      hold_d = bus.m_data;
      hold_l = bus.m_last;
    end else begin
      hold_v = 1'b0;
    end
  end

  // All stimulus tasks enter and leave just after a rising edge.
  task automatic start_cmd(input int l, input logic [DW-1:0] d);
    bus.start = 1'b1; bus.len = LW'(l); bus.divisor = d;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send(input int n, input int prob, input int mid_at);
    int i = 0, guard = 0;
    bit acc, fired = 0;
    while (i < n && guard < 2000) begin
      bus.s_valid = ($urandom_range(0, 99) < prob);
      bus.s_data  = dvals[i];
      bus.start   = 1'b0;
      if (i == mid_at && !fired) begin
        bus.start = 1'b1; bus.divisor = 1; bus.len = 3; fired = 1;
      end
      @(negedge clk);
      acc = bus.s_valid && bus.s_ready;
      if (acc) begin
        sb.push_back('{q: dvals[i] / cur_div, last: (i == n - 1)});
        if (i == 0) first_acc_cyc = cyc + 1;
      end
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    bus.s_valid = 1'b0;
    bus.start = 1'b0;
    if (guard >= 2000) begin
      total++; bad++;
      $display("FAIL send_timeout: got %0d accepts want %0d", i, n);
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    bit got = 0;
    while (!got && n < budget) begin
      @(negedge clk);
      if (done) got = 1;
      n++;
    end
    chk("done_seen", got, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input int l, input logic [DW-1:0] d, input int prob,
                         input int mode, input bit fixed, input int mid_at);
    int o0, d0;
    rmode = mode;
    o0 = out_cnt; d0 = done_cnt;
    cur_div = d;
    if (!fixed) begin
      dvals.delete();
      for (int i = 0; i < l; i++) dvals.push_back($urandom);
    end
    start_cmd(l, d);
    chk("busy_after_start", busy, 1);
    chk("err_after_start", err_div0, 0);
    chk("div_b_latched", div_b, d);
    send(l, prob, mid_at);
    @(negedge clk);
    chk("s_ready_after_last", bus.s_ready, 0);
    @(posedge clk); #1;
    wait_done(l * 4 + 300);
    repeat (2) @(posedge clk); #1;
    chk("scoreboard_empty", sb.size(), 0);
    chk("out_count", out_cnt - o0, l);
    chk("done_count", done_cnt - d0, 1);
    chk("busy_idle", busy, 0);
    chk("div_b_held", div_b, d);
    rmode = 0;
  endtask

  initial begin
    int d0, o0;
    bus.start = 0; bus.len = 0; bus.divisor = 0;
    bus.s_valid = 0; bus.s_data = 0;

    // Reset state
    #12;
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_m_last", bus.m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_div0, 0);
    chk("rst_div_en", div_en, 0);
    chk("rst_div_b", div_b, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic vector with latency measurement
    dvals.delete();
    dvals.push_back(100); dvals.push_back(55); dvals.push_back(9); dvals.push_back(1000);
    lat_arm = 1;
    run_vec(4, 10, 100, 0, 1, -1);
    chk("latency", first_val_cyc - first_acc_cyc, LAT);

    // Backpressure, input bubbles, random ready
    run_vec(8, 3, 100, 1, 0, -1);
    run_vec(16, 7, 50, 0, 0, -1);
    run_vec(12, 1 + $urandom_range(0, 1000), 70, 2, 0, -1);

    // Divide by zero
    d0 = done_cnt; o0 = out_cnt;
    start_cmd(5, 0);
    chk("div0_err", err_div0, 1);
    chk("div0_busy", busy, 0);
    bus.s_valid = 1; bus.s_data = 77;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("div0_s_ready", bus.s_ready, 0);
      @(posedge clk); #1;
    end
    bus.s_valid = 0;
    chk("div0_done_count", done_cnt - d0, 1);
    chk("div0_no_output", out_cnt - o0, 0);
    run_vec(3, 2, 100, 0, 0, -1);

    // len==0
    d0 = done_cnt; o0 = out_cnt;
    start_cmd(0, 5);
    repeat (80) @(posedge clk); #1;
    chk("len0_done_count", done_cnt - d0, 1);
    chk("len0_no_output", out_cnt - o0, 0);
    chk("len0_busy", busy, 0);

    // Start during RUN is ignored
    run_vec(6, 9, 100, 0, 0, 2);

    // Reset mid-drain
    rmode = 0;
    cur_div = 5;
    dvals.delete();
    for (int i = 0; i < 4; i++) dvals.push_back($urandom);
    start_cmd(4, 5);
    send(4, 100, -1);
    repeat (20) @(posedge clk); #1;
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_m_valid", bus.m_valid, 0);
    chk("mid_rst_m_data", bus.m_data, 0);
    chk("mid_rst_m_last", bus.m_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_div_en", div_en, 0);
    chk("mid_rst_div_b", div_b, 0);
    chk("mid_rst_s_ready", bus.s_ready, 0);
    sb.delete();
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(3, 4, 100, 0, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
